// File: rtl/poly5_horner_seq.sv
// Sequential Horner evaluator for a 5th-order Q16.16 polynomial on one shared multiplier.
// Define POLY5_HORNER_SAT_EN to saturate every accumulate instead of wrapping.
module poly5_horner_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        pushin,
    input  logic [3:0]  opin,
    input  logic [31:0] datain,
    output logic        busy,
    output logic        drop,
    output logic        pushout,
    output logic [31:0] dataout
);

    localparam logic [31:0] ONE_Q16 = 32'h0001_0000;
    localparam logic [3:0]  OP_X    = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ADD
    } state_t;

    state_t      state;
    logic [31:0] coef [0:5];
    logic [31:0] work [0:4];
    logic [31:0] x;
    logic [31:0] acc;
    logic [31:0] prod;
    logic [2:0]  k;

    logic        x_push;
    logic [31:0] mag_acc;
    logic [31:0] mag_x;
    logic [63:0] mag_prod;
    logic [63:0] mul_full;
    logic [31:0] mul_q;
    logic [31:0] addend;
    logic [31:0] sum_raw;
    logic [31:0] add_q;
    logic        unused_mul_bits;

    assign x_push = pushin && (opin == OP_X);

    // Sign-magnitude multiply so the truncation matches the reference rounding exactly.
    always_comb begin
        mag_acc  = acc[31] ? (~acc + 32'd1) : acc;
        mag_x    = x[31] ? (~x + 32'd1) : x;
        mag_prod = {32'd0, mag_acc} * {32'd0, mag_x};
        mul_full = (acc[31] ^ x[31]) ? (~mag_prod + 64'd1) : mag_prod;
        mul_q    = mul_full[47:16];
    end

    assign unused_mul_bits = ^{mul_full[63:48], mul_full[15:0]};

    always_comb begin
        addend = work[0];
        case (k)
            3'd1:    addend = work[1];
            3'd2:    addend = work[2];
            3'd3:    addend = work[3];
            3'd4:    addend = work[4];
            default: addend = work[0];
        endcase
    end

    always_comb begin
        sum_raw = prod + addend;
        add_q   = sum_raw;
`ifdef POLY5_HORNER_SAT_EN
        if ((prod[31] == addend[31]) && (sum_raw[31] != prod[31])) begin
            add_q = prod[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            x       <= 32'd0;
            acc     <= 32'd0;
            prod    <= 32'd0;
            k       <= 3'd0;
            busy    <= 1'b0;
            drop    <= 1'b0;
            pushout <= 1'b0;
            dataout <= 32'd0;
            for (int i = 0; i < 6; i++) coef[i] <= ONE_Q16;
            for (int i = 0; i < 5; i++) work[i] <= ONE_Q16;
        end else begin
            drop    <= 1'b0;
            pushout <= 1'b0;

            // The programmed bank is always writable; the running evaluation uses its snapshot.
            for (int i = 0; i < 6; i++) begin
                if (pushin && (opin == 4'(i))) coef[i] <= datain;
            end

            if (x_push && busy) drop <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (x_push) begin
                        x     <= datain;
                        acc   <= coef[5];
                        k     <= 3'd4;
                        busy  <= 1'b1;
                        state <= S_MUL;
                        for (int i = 0; i < 5; i++) work[i] <= coef[i];
                    end
                end
                S_MUL: begin
                    prod  <= mul_q;
                    state <= S_ADD;
                end
                S_ADD: begin
                    acc <= add_q;
                    if (k != 3'd0) begin
                        k     <= k - 3'd1;
                        state <= S_MUL;
                    end else begin
                        dataout <= add_q;
                        pushout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly5_horner_seq.sv
// Self-checking bench for poly5_horner_seq: directed scenarios plus randomized evaluations
// against an arithmetic Horner reference model.
module tb_poly5_horner_seq;

    localparam logic [31:0] ONE_Q16 = 32'h0001_0000;

    logic        clk;
    logic        rst;
    logic        pushin;
    logic [3:0]  opin;
    logic [31:0] datain;
    logic        busy;
    logic        drop;
    logic        pushout;
    logic [31:0] dataout;

    int checks;
    int errors;
    int busyCycles;
    logic [31:0] bank [6];
    logic [31:0] snap [6];

    poly5_horner_seq dut (
        .clk     (clk),
        .rst     (rst),
        .pushin  (pushin),
        .opin    (opin),
        .datain  (datain),
        .busy    (busy),
        .drop    (drop),
        .pushout (pushout),
        .dataout (dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q16.16 product: exact signed product, keep bits 47:16 (floor of the scaled value).
    function automatic logic [31:0] refMul(input logic [31:0] p, input logic [31:0] q);
        longint sp;
        sp = longint'($signed(p)) * longint'($signed(q));
        return sp[47:16];
    endfunction

    function automatic logic [31:0] refAdd(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef POLY5_HORNER_SAT_EN
        if (s > longint'(32'sh7FFF_FFFF)) return 32'h7FFF_FFFF;
        if (s < -longint'(64'h8000_0000)) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    function automatic logic [31:0] refEval(input logic [31:0] xv);
        logic [31:0] a;
        a = snap[5];
        for (int i = 4; i >= 0; i--) a = refAdd(refMul(a, xv), snap[i]);
        return a;
    endfunction

    function automatic logic [31:0] randVal();
        if ($urandom_range(0, 1) == 1) return 32'($urandom_range(0, 32'h0008_0000) - 32'h0004_0000);
        return $urandom();
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic p, input logic [3:0] op, input logic [31:0] d);
        pushin = p;
        opin   = op;
        datain = d;
        @(posedge clk);
        #1;
        pushin = 1'b0;
        opin   = 4'd0;
        datain = 32'd0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(1'b0, 4'd0, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) bank[i] = ONE_Q16;
    endtask

    task automatic writeCoef(input int idx, input logic [31:0] v);
        applyStimulus(1'b1, 4'(idx), v);
        bank[idx] = v;
    endtask

    task automatic waitResult(input int expCycles, input logic [31:0] want, input string tag);
        int n;
        n = 0;
        busyCycles = 0;
        for (int i = 1; i <= 30; i++) begin
            applyStimulus(1'b0, 4'd0, 32'd0);
            n = i;
            if (busy) busyCycles++;
            if (pushout) break;
        end
        checkOutput({tag, "_latency"}, 32'(n), 32'(expCycles));
        checkOutput({tag, "_data"}, dataout, want);
        applyStimulus(1'b0, 4'd0, 32'd0);
        checkOutput({tag, "_pulse"}, {31'd0, pushout}, 32'd0);
    endtask

    task automatic runEval(input logic [31:0] xv, input logic [31:0] want, input string tag);
        applyStimulus(1'b1, 4'd15, xv);
        checkOutput({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
        waitResult(10, want, tag);
        checkOutput({tag, "_busy_len"}, 32'(busyCycles + 1), 32'd10);
    endtask

    task automatic quietCycles(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b0, 4'd0, 32'd0);
            if (pushout) seen++;
        end
        checkOutput(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] xv;
        logic [31:0] expv;
        int r;
        int idx;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        pushin = 1'b0;
        opin   = 4'd0;
        datain = 32'd0;

        resetDut();
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_drop", {31'd0, drop}, 32'd0);
        checkOutput("rst_pushout", {31'd0, pushout}, 32'd0);
        checkOutput("rst_dataout", dataout, 32'd0);

        runEval(32'h0001_0000, 32'h0006_0000, "x1");
        resetDut();
        runEval(32'h0002_0000, 32'h003F_0000, "x2");

        for (int i = 1; i < 6; i++) writeCoef(i, 32'd0);
        writeCoef(0, 32'h1234_5678);
        runEval(32'h0003_0000, 32'h1234_5678, "a0only");
        resetDut();
        runEval(32'hFFFF_0000, 32'h0000_0000, "xneg1");

        // Coefficient write at E3 and rejected x push at E4 during one evaluation.
        resetDut();
        applyStimulus(1'b1, 4'd15, ONE_Q16);
        applyStimulus(1'b0, 4'd0, 32'd0);
        applyStimulus(1'b0, 4'd0, 32'd0);
        writeCoef(0, 32'h0005_0000);
        applyStimulus(1'b1, 4'd15, ONE_Q16);
        checkOutput("drop_pulse", {31'd0, drop}, 32'd1);
        applyStimulus(1'b0, 4'd0, 32'd0);
        checkOutput("drop_single", {31'd0, drop}, 32'd0);
        waitResult(5, 32'h0006_0000, "midwrite");
        quietCycles(12, "extra_pushout");
        runEval(ONE_Q16, 32'h000A_0000, "newa0");

        // Reset at E5 aborts the evaluation.
        applyStimulus(1'b1, 4'd15, ONE_Q16);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'd0, 32'd0);
        resetDut();
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_dataout", dataout, 32'd0);
        quietCycles(15, "abort_pushout");
        runEval(ONE_Q16, 32'h0006_0000, "after_abort");

        for (int i = 0; i < 6; i++) writeCoef(i, 32'h7FFF_0000);
        for (int i = 0; i < 6; i++) snap[i] = bank[i];
`ifdef POLY5_HORNER_SAT_EN
        expv = 32'h7FFF_FFFF;
`else
        expv = refEval(32'h7FFF_0000);
`endif
        runEval(32'h7FFF_0000, expv, "bigval");

        // Randomized evaluations with random beats injected while busy.
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 3);
            for (int j = 0; j < r; j++) writeCoef($urandom_range(0, 5), randVal());
            if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, 4'($urandom_range(6, 14)), $urandom());
            xv = randVal();
            for (int i = 0; i < 6; i++) snap[i] = bank[i];
            expv = refEval(xv);
            applyStimulus(1'b1, 4'd15, xv);
            checkOutput("rnd_busy", {31'd0, busy}, 32'd1);
            for (int c = 1; c <= 10; c++) begin
                r = $urandom_range(0, 3);
                case (r)
                    1: begin
                        idx = $urandom_range(0, 5);
                        writeCoef(idx, randVal());
                    end
                    2: applyStimulus(1'b1, 4'd15, randVal());
                    3: applyStimulus(1'b1, 4'($urandom_range(6, 14)), $urandom());
                    default: applyStimulus(1'b0, 4'd0, 32'd0);
                endcase
                checkOutput("rnd_drop", {31'd0, drop}, {31'd0, (r == 2)});
                if (c < 10) begin
                    checkOutput("rnd_early_pushout", {31'd0, pushout}, 32'd0);
                end else begin
                    checkOutput("rnd_pushout", {31'd0, pushout}, 32'd1);
                    checkOutput("rnd_data", dataout, expv);
                    checkOutput("rnd_busy_end", {31'd0, busy}, 32'd0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
